// File: rtl/reg_universal_nb_if.sv
// rtl/reg_universal_nb_if.sv - control, data and status bundle for the universal register
// Purpose: groups every non-clock/reset signal of reg_universal_nb.
// Ports (master drives / slave receives):
//   en, mode[1:0], d[WIDTH-1:0], sin_msb, sin_lsb, start, dir, shamt[CNT_W-1:0]
// Ports (slave drives / master receives):
//   q[WIDTH-1:0], sout_msb, sout_lsb, busy, done
interface reg_universal_nb_if #(
    parameter int WIDTH = 8
) ();
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_msb;
    logic             sin_lsb;
    logic             start;
    logic             dir;
    logic [CNT_W-1:0] shamt;
    logic [WIDTH-1:0] q;
    logic             sout_msb;
    logic             sout_lsb;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, d, sin_msb, sin_lsb, start, dir, shamt,
        input  q, sout_msb, sout_lsb, busy, done
    );

    modport slave (
        input  en, mode, d, sin_msb, sin_lsb, start, dir, shamt,
        output q, sout_msb, sout_lsb, busy, done
    );
endinterface

// File: rtl/reg_universal_nb.sv
// rtl/reg_universal_nb.sv - N-bit universal shift/load register with auto-shift engine
// Purpose: per enabled edge holds, shifts right, shifts left or loads; an auto-shift
//          engine performs a programmed number of single-bit shifts with busy/done.
// Ports:
//   i_clk  - rising-edge clock
//   i_rst  - synchronous active-high reset (wins over en=0)
//   s_bus  - reg_universal_nb_if.slave: en, mode, d, sin_msb, sin_lsb, start, dir,
//            shamt in; q, sout_msb, sout_lsb, busy, done out
module reg_universal_nb #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    reg_universal_nb_if.slave    s_bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_dir, w_dir_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;

    logic [WIDTH-1:0] w_q_right;
    logic [WIDTH-1:0] w_q_left;

    // Serial inputs are taken live on every shift, never latched at start.
    assign w_q_right = {s_bus.sin_msb, r_q[WIDTH-1:1]};
    assign w_q_left  = {r_q[WIDTH-2:0], s_bus.sin_lsb};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_q     <= RST_VAL;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (s_bus.en) begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_busy_nxt  = r_busy;
        // done is a single-cycle pulse, so it falls unless re-raised below.
        w_done_nxt  = 1'b0;

        case (r_state)
            S_SHIFT: begin
                w_q_nxt   = r_dir ? w_q_left : w_q_right;
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                if (s_bus.start) begin
                    // A zero-length request completes immediately without entering SHIFT.
                    if (s_bus.shamt != '0) begin
                        w_state_nxt = S_SHIFT;
                        w_cnt_nxt   = s_bus.shamt;
                        w_dir_nxt   = s_bus.dir;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    case (s_bus.mode)
                        MODE_RIGHT: w_q_nxt = w_q_right;
                        MODE_LEFT:  w_q_nxt = w_q_left;
                        MODE_LOAD:  w_q_nxt = s_bus.d;
                        MODE_HOLD:  w_q_nxt = r_q;
                        default:    w_q_nxt = r_q;
                    endcase
                end
            end
        endcase
    end

    assign s_bus.q        = r_q;
    assign s_bus.sout_msb = r_q[WIDTH-1];
    assign s_bus.sout_lsb = r_q[0];
    assign s_bus.busy     = r_busy;
    assign s_bus.done     = r_done;
endmodule
